// File: rtl/adc_stream_sink.sv
// adc_stream_sink: AXI4-Stream sink for the AD9467 receiver sample stream.
// Checks frame length against FRAME_LEN, counts frames and framing errors, and
// captures one armed window of 2^DEPTH_LOG2 samples into a buffer with a
// synchronous read port.
// Optional build macro: ADC_STREAM_SINK_THROTTLE_EN drives tready from a
// 16-bit LFSR (taps 16,14,13,11, seed 0xACE1) for pseudo-random backpressure.
//
// Capture FSM states:
//   state    | meaning
//   IDLE     | no capture requested
//   WAIT_SOF | armed, waiting for the first beat of the next frame
//   CAPTURE  | writing beats into the buffer
//   DONE_ST  | buffer full, holds until the next arm

module adc_stream_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  arm,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [31:0]           frame_count,
  output logic                  len_err,
  output logic [15:0]           len_err_count
);

  localparam logic [15:0]           FL        = 16'(FRAME_LEN);
  localparam logic [DEPTH_LOG2-1:0] WPTR_LAST = '1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE_ST} state_t;

  state_t                state;
  logic                  sof;
  logic [15:0]           beat_cnt;
  logic                  err_seen;
  logic [DEPTH_LOG2-1:0] wptr;

  logic                  beat;
  logic [15:0]           beat_idx;
  logic                  seen_eff;
  logic                  frame_err;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign beat = s_axis_tvalid & s_axis_tready;

`ifdef ADC_STREAM_SINK_THROTTLE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // LFSR advances every cycle; tready is its registered bit 0
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      lfsr          <= 16'hACE1;
      s_axis_tready <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr_fb};
      s_axis_tready <= lfsr[0];
    end
  end
`else
  // tready rises on the first edge after reset and stays high
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) s_axis_tready <= 1'b0;
    else            s_axis_tready <= 1'b1;
  end
`endif

  // Index of the current beat within its frame, and the one-error-per-frame gate
  always_comb begin
    beat_idx = 16'd1;
    if (!sof) beat_idx = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
    seen_eff  = sof ? 1'b0 : err_seen;
    frame_err = beat && !seen_eff && (s_axis_tlast != (beat_idx == FL));
  end

  // Frame position tracking: sof flag, beat counter, per-frame error latch
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      sof      <= 1'b1;
      beat_cnt <= 16'd0;
      err_seen <= 1'b0;
    end else if (beat) begin
      sof      <= s_axis_tlast;
      beat_cnt <= beat_idx;
      err_seen <= seen_eff | frame_err;
    end
  end

  // Frame and error counters; clear takes priority over a same-cycle event
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      frame_count   <= 32'd0;
      len_err       <= 1'b0;
      len_err_count <= 16'd0;
    end else if (clear) begin
      frame_count   <= 32'd0;
      len_err       <= 1'b0;
      len_err_count <= 16'd0;
    end else begin
      if (beat && s_axis_tlast) frame_count <= frame_count + 32'd1;
      if (frame_err) begin
        len_err <= 1'b1;
        if (len_err_count != 16'hFFFF) len_err_count <= len_err_count + 16'd1;
      end
    end
  end

  // Capture FSM with registered busy/done
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state <= IDLE;
      wptr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= WAIT_SOF;
            busy  <= 1'b1;
          end
        end
        WAIT_SOF: begin
          if (beat && sof) begin
            wptr  <= {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (beat) begin
            wptr <= wptr + 1'b1;
            if (wptr == WPTR_LAST) begin
              state <= DONE_ST;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE_ST: begin
          if (arm) begin
            state <= WAIT_SOF;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer write port selection
  always_comb begin
    wr_en   = beat && (((state == WAIT_SOF) && sof) || (state == CAPTURE));
    wr_addr = (state == CAPTURE) ? wptr : '0;
  end

  // Buffer storage; contents are never reset
  always_ff @(posedge s_aclk) begin
    if (wr_en) mem[wr_addr] <= s_axis_tdata;
  end

  // Synchronous read, returns the pre-write word on an address collision
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) rd_data <= '0;
    else            rd_data <= mem[rd_addr];
  end

endmodule
